// File: rtl/tdpu_gemv_sched.sv
// GEMV sequencer for one ternary dot-product core: fetches weight/activation tiles,
// streams them into the core, accumulates chunk partials per batch vector and drains y[b][r].
module tdpu_gemv_sched #(
    parameter int LEN        = 16,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_ROWS   = 256,
    parameter int MAX_CHUNKS = 64,
    parameter int MAX_BATCH  = 8,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         i_start,
    input  logic [$clog2(MAX_ROWS+1)-1:0]                i_cfg_rows,
    input  logic [$clog2(MAX_CHUNKS+1)-1:0]              i_cfg_chunks,
    input  logic [$clog2(MAX_BATCH+1)-1:0]               i_cfg_batch,
    output logic                                         o_busy,
    output logic                                         o_done,
    output logic                                         o_wt_rd_en,
    output logic [$clog2(MAX_ROWS*MAX_CHUNKS)-1:0]       o_wt_rd_addr,
    input  logic [2*LEN-1:0]                             i_wt_rd_data,
    output logic                                         o_act_rd_en,
    output logic [$clog2(MAX_BATCH*MAX_CHUNKS)-1:0]      o_act_rd_addr,
    input  logic [LEN*DATA_WIDTH-1:0]                    i_act_rd_data,
    output logic                                         o_core_load_weight,
    output logic [2*LEN-1:0]                             o_core_weight,
    output logic                                         o_core_data_valid,
    output logic [LEN*DATA_WIDTH-1:0]                    o_core_data,
    input  logic                                         i_core_data_ready,
    input  logic signed [31:0]                           i_core_result,
    output logic                                         o_res_valid,
    input  logic                                         i_res_ready,
    output logic [$clog2(MAX_ROWS)-1:0]                  o_res_row,
    output logic [$clog2(MAX_BATCH)-1:0]                 o_res_batch,
    output logic signed [ACC_WIDTH-1:0]                  o_res_data
);
    localparam int RW = $clog2(MAX_ROWS + 1);
    localparam int CW = $clog2(MAX_CHUNKS + 1);
    localparam int BW = $clog2(MAX_BATCH + 1);
    localparam int RI = $clog2(MAX_ROWS);
    localparam int CI = $clog2(MAX_CHUNKS);
    localparam int BI = $clog2(MAX_BATCH);
    localparam int WA = $clog2(MAX_ROWS * MAX_CHUNKS);
    localparam int AA = $clog2(MAX_BATCH * MAX_CHUNKS);
    localparam int PW = $clog2(MAX_BATCH * MAX_CHUNKS + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_STREAM, S_FLUSH, S_DRAIN, S_DONE} state_t;

    state_t                       r_state;
    logic [RW-1:0]                r_cfg_rows;
    logic [CW-1:0]                r_cfg_chunks;
    logic [BW-1:0]                r_cfg_batch;
    logic [RI-1:0]                r_row;
    logic [CI-1:0]                r_chunk;
    logic [BI-1:0]                r_b;
    logic [CI-1:0]                r_cres;
    logic [BI-1:0]                r_bres;
    logic [PW-1:0]                r_pending;
    logic                         r_row_res_done;
    logic                         r_busy;
    logic                         r_done;
    logic                         r_wt_rd_en;
    logic [WA-1:0]                r_wt_rd_addr;
    logic                         r_act_rd_en;
    logic [AA-1:0]                r_act_rd_addr;
    logic                         r_load_w;
    logic                         r_data_valid;
    logic                         r_res_valid;
    logic signed [ACC_WIDTH-1:0]  r_acc [MAX_BATCH];

    logic                         w_cfg_zero;
    logic                         w_last_b;
    logic                         w_last_c;
    logic                         w_last_r;
    logic                         w_take;
    logic                         w_res_last_b;
    logic                         w_res_last_c;
    logic signed [ACC_WIDTH-1:0]  w_res_ext;

    assign w_cfg_zero   = (i_cfg_rows == '0) || (i_cfg_chunks == '0) || (i_cfg_batch == '0);
    assign w_last_b     = (BW'(r_b) == r_cfg_batch - BW'(1));
    assign w_last_c     = (CW'(r_chunk) == r_cfg_chunks - CW'(1));
    assign w_last_r     = (RW'(r_row) == r_cfg_rows - RW'(1));
    // Strobes beyond the number of issued-but-unanswered chunks are stray and dropped
    assign w_take       = i_core_data_ready && (r_pending != '0);
    assign w_res_last_b = (BW'(r_bres) == r_cfg_batch - BW'(1));
    assign w_res_last_c = (CW'(r_cres) == r_cfg_chunks - CW'(1));
    assign w_res_ext    = ACC_WIDTH'(i_core_result);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_cfg_rows     <= '0;
            r_cfg_chunks   <= '0;
            r_cfg_batch    <= '0;
            r_row          <= '0;
            r_chunk        <= '0;
            r_b            <= '0;
            r_cres         <= '0;
            r_bres         <= '0;
            r_pending      <= '0;
            r_row_res_done <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_wt_rd_en     <= 1'b0;
            r_wt_rd_addr   <= '0;
            r_act_rd_en    <= 1'b0;
            r_act_rd_addr  <= '0;
            r_load_w       <= 1'b0;
            r_data_valid   <= 1'b0;
            r_res_valid    <= 1'b0;
        end else begin
            r_load_w     <= r_wt_rd_en;
            r_data_valid <= r_act_rd_en;
            r_done       <= 1'b0;
            r_pending    <= r_pending + PW'(r_data_valid) - PW'(w_take);
            if (w_take) begin
                if (w_res_last_b) begin
                    r_bres <= '0;
                    if (w_res_last_c) begin
                        r_cres         <= '0;
                        r_row_res_done <= 1'b1;
                    end else begin
                        r_cres <= r_cres + CI'(1);
                    end
                end else begin
                    r_bres <= r_bres + BI'(1);
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (w_cfg_zero) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_cfg_rows     <= i_cfg_rows;
                            r_cfg_chunks   <= i_cfg_chunks;
                            r_cfg_batch    <= i_cfg_batch;
                            r_row          <= '0;
                            r_chunk        <= '0;
                            r_cres         <= '0;
                            r_bres         <= '0;
                            r_row_res_done <= 1'b0;
                            r_wt_rd_addr   <= '0;
                            r_wt_rd_en     <= 1'b1;
                            r_busy         <= 1'b1;
                            r_state        <= S_LOAD_W;
                        end
                    end
                end
                S_LOAD_W: begin
                    r_wt_rd_en    <= 1'b0;
                    r_act_rd_en   <= 1'b1;
                    r_act_rd_addr <= AA'(r_chunk);
                    r_b           <= '0;
                    r_state       <= S_STREAM;
                end
                S_STREAM: begin
                    // Tiles are laid out r-major, so the weight address simply counts up
                    if (w_last_b) begin
                        r_act_rd_en <= 1'b0;
                        if (!w_last_c) begin
                            r_chunk      <= r_chunk + CI'(1);
                            r_wt_rd_addr <= r_wt_rd_addr + WA'(1);
                            r_wt_rd_en   <= 1'b1;
                            r_state      <= S_LOAD_W;
                        end else begin
                            r_state <= S_FLUSH;
                        end
                    end else begin
                        r_b           <= r_b + BI'(1);
                        r_act_rd_addr <= r_act_rd_addr + AA'(r_cfg_chunks);
                    end
                end
                S_FLUSH: begin
                    if (r_row_res_done || (w_take && w_res_last_b && w_res_last_c)) begin
                        r_row_res_done <= 1'b0;
                        r_res_valid    <= 1'b1;
                        r_b            <= '0;
                        r_state        <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (i_res_ready) begin
                        if (w_last_b) begin
                            r_res_valid <= 1'b0;
                            if (!w_last_r) begin
                                r_row        <= r_row + RI'(1);
                                r_chunk      <= '0;
                                r_wt_rd_addr <= r_wt_rd_addr + WA'(1);
                                r_wt_rd_en   <= 1'b1;
                                r_state      <= S_LOAD_W;
                            end else begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end
                        end else begin
                            r_b <= r_b + BI'(1);
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // First chunk of a row overwrites, so the accumulators never need clearing
    always_ff @(posedge clk) begin
        if (w_take) begin
            if (r_cres == '0) r_acc[r_bres] <= w_res_ext;
            else              r_acc[r_bres] <= r_acc[r_bres] + w_res_ext;
        end
    end

    assign o_busy             = r_busy;
    assign o_done             = r_done;
    assign o_wt_rd_en         = r_wt_rd_en;
    assign o_wt_rd_addr       = r_wt_rd_addr;
    assign o_act_rd_en        = r_act_rd_en;
    assign o_act_rd_addr      = r_act_rd_addr;
    assign o_core_load_weight = r_load_w;
    assign o_core_weight      = i_wt_rd_data;
    assign o_core_data_valid  = r_data_valid;
    assign o_core_data        = i_act_rd_data;
    assign o_res_valid        = r_res_valid;
    assign o_res_row          = r_res_valid ? r_row : '0;
    assign o_res_batch        = r_res_valid ? r_b : '0;
    assign o_res_data         = r_res_valid ? r_acc[r_b] : '0;
endmodule

// File: tb/tb_tdpu_gemv_sched.sv
// Bench for tdpu_gemv_sched: SRAM and 3-cycle core models around the DUT, with results
// compared against y[b][r] computed directly from the memory contents.
module tb_tdpu_gemv_sched;
    localparam int LEN = 16;
    localparam int DW  = 8;
    localparam int LIMIT = 3000;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               i_start;
    logic [8:0]         i_cfg_rows;
    logic [6:0]         i_cfg_chunks;
    logic [3:0]         i_cfg_batch;
    logic               o_busy, o_done;
    logic               o_wt_rd_en;
    logic [13:0]        o_wt_rd_addr;
    logic [2*LEN-1:0]   i_wt_rd_data;
    logic               o_act_rd_en;
    logic [8:0]         o_act_rd_addr;
    logic [LEN*DW-1:0]  i_act_rd_data;
    logic               o_core_load_weight;
    logic [2*LEN-1:0]   o_core_weight;
    logic               o_core_data_valid;
    logic [LEN*DW-1:0]  o_core_data;
    logic               i_core_data_ready;
    logic signed [31:0] i_core_result;
    logic               o_res_valid;
    logic               i_res_ready;
    logic [7:0]         o_res_row;
    logic [2:0]         o_res_batch;
    logic signed [31:0] o_res_data;

    tdpu_gemv_sched dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start),
        .i_cfg_rows(i_cfg_rows), .i_cfg_chunks(i_cfg_chunks), .i_cfg_batch(i_cfg_batch),
        .o_busy(o_busy), .o_done(o_done),
        .o_wt_rd_en(o_wt_rd_en), .o_wt_rd_addr(o_wt_rd_addr), .i_wt_rd_data(i_wt_rd_data),
        .o_act_rd_en(o_act_rd_en), .o_act_rd_addr(o_act_rd_addr), .i_act_rd_data(i_act_rd_data),
        .o_core_load_weight(o_core_load_weight), .o_core_weight(o_core_weight),
        .o_core_data_valid(o_core_data_valid), .o_core_data(o_core_data),
        .i_core_data_ready(i_core_data_ready), .i_core_result(i_core_result),
        .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
        .o_res_row(o_res_row), .o_res_batch(o_res_batch), .o_res_data(o_res_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2*LEN-1:0]  wt_mem  [256*64];
    logic [LEN*DW-1:0] act_mem [8*64];

    always @(posedge clk) begin
        if (o_wt_rd_en)  i_wt_rd_data  <= wt_mem[o_wt_rd_addr];
        if (o_act_rd_en) i_act_rd_data <= act_mem[o_act_rd_addr];
    end

    function automatic int dot(input logic [2*LEN-1:0] w, input logic [LEN*DW-1:0] x);
        int s = 0;
        for (int l = 0; l < LEN; l++)
            s += int'($signed(w[2*l +: 2])) * int'($signed(x[DW*l +: DW]));
        return s;
    endfunction

    function automatic int ref_y(input int r, input int b, input int chunks);
        int s = 0;
        for (int c = 0; c < chunks; c++)
            s += dot(wt_mem[r*chunks + c], act_mem[b*chunks + c]);
        return s;
    endfunction

    // Core model: weights latched on load strobe, result appears 3 cycles after data strobe
    logic [2*LEN-1:0]   core_w;
    logic [2:0]         core_v;
    logic signed [31:0] core_r0, core_r1, core_r2;
    logic               stray_rdy = 1'b0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_v <= '0;
        end else begin
            core_v  <= {core_v[1:0], o_core_data_valid};
            core_r0 <= dot(core_w, o_core_data);
            core_r1 <= core_r0;
            core_r2 <= core_r1;
            if (o_core_load_weight) core_w <= o_core_weight;
        end
    end
    assign i_core_data_ready = core_v[2] | stray_rdy;
    assign i_core_result     = core_r2;

    int tests_run = 0;
    int tests_failed = 0;
    int t0, n_wt, n_act, n_busy, first_res, done_cyc, ovl, hold_bad, n_hold;
    int q_r[$];
    int q_b[$];
    int q_d[$];

    task automatic fill_random(input int rows, input int chunks, input int batch);
        for (int i = 0; i < rows*chunks; i++)
            for (int l = 0; l < LEN; l++) begin
                int t = $urandom_range(0, 2);
                wt_mem[i][2*l +: 2] = (t == 0) ? 2'b00 : (t == 1) ? 2'b01 : 2'b11;
            end
        for (int i = 0; i < batch*chunks; i++)
            for (int l = 0; l < LEN; l++) act_mem[i][DW*l +: DW] = 8'($urandom);
    endtask

    // Runs one job to o_done; rdy_mode 0: always ready, 1: random, 2: stall 5 valid cycles
    task automatic run_job(input int rows, input int chunks, input int batch,
                           input int rdy_mode, input bit inject, input string name);
        bit done_seen = 0;
        bit prev_stall = 0;
        bit busy_now;
        int stall_left = (rdy_mode == 2) ? 5 : 0;
        int h_r = 0, h_b = 0, h_d = 0;
        int exp_n;
        n_wt = 0; n_act = 0; n_busy = 0; first_res = -1; done_cyc = -1;
        ovl = 0; hold_bad = 0; n_hold = 0;
        q_r.delete(); q_b.delete(); q_d.delete();
        i_cfg_rows = 9'(rows); i_cfg_chunks = 7'(chunks); i_cfg_batch = 4'(batch);
        i_res_ready = (rdy_mode != 2);
        i_start = 1'b1;
        t0 = cyc;
        for (int k = 0; k < LIMIT && !done_seen; k++) begin
            @(negedge clk);
            busy_now = o_busy;
            if (o_busy) n_busy++;
            if (o_wt_rd_en) n_wt++;
            if (o_act_rd_en) n_act++;
            if (o_core_load_weight && o_core_data_valid) ovl++;
            if (o_res_valid) begin
                if (first_res < 0) first_res = cyc;
                if (prev_stall) begin
                    n_hold++;
                    if (o_res_row !== 8'(h_r) || o_res_batch !== 3'(h_b) || o_res_data !== h_d)
                        hold_bad++;
                end
                if (i_res_ready) begin
                    q_r.push_back(int'(o_res_row));
                    q_b.push_back(int'(o_res_batch));
                    q_d.push_back(int'(o_res_data));
                end else if (stall_left > 0) begin
                    stall_left--;
                end
                prev_stall = !i_res_ready;
                h_r = int'(o_res_row); h_b = int'(o_res_batch); h_d = int'(o_res_data);
            end else begin
                prev_stall = 0;
            end
            if (o_done) begin
                done_seen = 1;
                done_cyc = cyc;
            end else begin
                @(posedge clk); #1;
                i_start = inject && busy_now;
                if (i_start) begin
                    i_cfg_rows   = 9'($urandom_range(1, 3));
                    i_cfg_chunks = 7'($urandom_range(1, 3));
                    i_cfg_batch  = 4'($urandom_range(1, 3));
                end
                case (rdy_mode)
                    0:       i_res_ready = 1'b1;
                    1:       i_res_ready = 1'($urandom_range(0, 1));
                    default: i_res_ready = (stall_left == 0);
                endcase
            end
        end
        @(posedge clk); #1;
        i_start = 1'b0;
        i_res_ready = 1'b0;
        tests_run++;
        if (!done_seen) begin
            tests_failed++;
            $display("[TB] FAIL %s timeout: no o_done within %0d cycles", name, LIMIT);
        end
        exp_n = (rows == 0 || chunks == 0 || batch == 0) ? 0 : rows * batch;
        tests_run++;
        if (q_d.size() !== exp_n) begin
            tests_failed++;
            $display("[TB] FAIL %s result_count: got %0d expected %0d", name, q_d.size(), exp_n);
        end
        for (int i = 0; i < exp_n && i < q_d.size(); i++) begin
            int er = i / batch;
            int eb = i % batch;
            int ed = ref_y(er, eb, chunks);
            tests_run++;
            if (q_r[i] !== er || q_b[i] !== eb || q_d[i] !== ed) begin
                tests_failed++;
                $display("[TB] FAIL %s result[%0d]: got r%0d b%0d %0d expected r%0d b%0d %0d",
                         name, i, q_r[i], q_b[i], q_d[i], er, eb, ed);
            end
        end
        tests_run++;
        if (ovl !== 0 || hold_bad !== 0) begin
            tests_failed++;
            $display("[TB] FAIL %s overlap/hold: got %0d/%0d expected 0/0", name, ovl, hold_bad);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_start = 1'b0; i_res_ready = 1'b0;
        i_cfg_rows = '0; i_cfg_chunks = '0; i_cfg_batch = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({o_busy, o_done, o_wt_rd_en, o_act_rd_en} !== 4'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0000",
                     {o_busy, o_done, o_wt_rd_en, o_act_rd_en});
        end
        tests_run++;
        if ({o_core_load_weight, o_core_data_valid, o_res_valid} !== 3'b0 || o_res_data !== 0) begin
            tests_failed++;
            $display("[TB] FAIL reset_data: got %b/%0d expected 000/0",
                     {o_core_load_weight, o_core_data_valid, o_res_valid}, o_res_data);
        end
        tests_run++;
        if (o_wt_rd_addr !== 0 || o_act_rd_addr !== 0) begin
            tests_failed++;
            $display("[TB] FAIL reset_addr: got %0d/%0d expected 0/0", o_wt_rd_addr, o_act_rd_addr);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        wt_mem[0]  = {LEN{2'b01}};
        act_mem[0] = {LEN{8'd1}};
        run_job(1, 1, 1, 0, 0, "single");
        tests_run++;
        if (q_d.size() < 1 || q_d[0] !== 16) begin
            tests_failed++;
            $display("[TB] FAIL single_value: got %0d expected 16", (q_d.size() > 0) ? q_d[0] : -1);
        end
        tests_run++;
        if (first_res - t0 !== 7 || done_cyc - t0 !== 8) begin
            tests_failed++;
            $display("[TB] FAIL single_timing: got valid+%0d done+%0d expected valid+7 done+8",
                     first_res - t0, done_cyc - t0);
        end
        tests_run++;
        if (n_busy !== 7 || n_wt !== 1 || n_act !== 1) begin
            tests_failed++;
            $display("[TB] FAIL single_counts: got busy %0d wt %0d act %0d expected 7 1 1",
                     n_busy, n_wt, n_act);
        end
    endtask

    task automatic test_two_chunks();
        wt_mem[0]  = {LEN{2'b01}};
        wt_mem[1]  = {LEN{2'b11}};
        act_mem[0] = {LEN{8'd3}};
        act_mem[1] = {LEN{8'd1}};
        run_job(1, 2, 1, 0, 0, "two_chunks");
        tests_run++;
        if (q_d.size() < 1 || q_d[0] !== 32) begin
            tests_failed++;
            $display("[TB] FAIL two_chunks_value: got %0d expected 32", (q_d.size() > 0) ? q_d[0] : -1);
        end
        tests_run++;
        if (n_wt !== 2 || n_act !== 2) begin
            tests_failed++;
            $display("[TB] FAIL two_chunks_reads: got wt %0d act %0d expected 2 2", n_wt, n_act);
        end
    endtask

    task automatic test_random_gemv();
        int rows, chunks, batch;
        fill_random(2, 3, 4);
        run_job(2, 3, 4, 0, 0, "gemv_2x3x4");
        for (int j = 0; j < 3; j++) begin
            rows = $urandom_range(1, 3); chunks = $urandom_range(1, 4); batch = $urandom_range(1, 8);
            fill_random(rows, chunks, batch);
            run_job(rows, chunks, batch, 1, 0, "gemv_random");
            tests_run++;
            if (n_wt !== rows*chunks || n_act !== rows*chunks*batch) begin
                tests_failed++;
                $display("[TB] FAIL gemv_random_reads: got wt %0d act %0d expected %0d %0d",
                         n_wt, n_act, rows*chunks, rows*chunks*batch);
            end
        end
    endtask

    task automatic test_drain_stall();
        fill_random(2, 2, 3);
        run_job(2, 2, 3, 2, 0, "drain_stall");
        tests_run++;
        if (n_hold < 4) begin
            tests_failed++;
            $display("[TB] FAIL drain_stall_held_cycles: got %0d expected >=4", n_hold);
        end
    endtask

    task automatic test_zero_cfg();
        int cfgs[3][3] = '{'{0, 2, 2}, '{2, 0, 2}, '{2, 2, 0}};
        for (int j = 0; j < 3; j++) begin
            run_job(cfgs[j][0], cfgs[j][1], cfgs[j][2], 0, 0, "zero_cfg");
            tests_run++;
            if (done_cyc - t0 !== 1 || n_wt !== 0 || n_act !== 0 || n_busy !== 0) begin
                tests_failed++;
                $display("[TB] FAIL zero_cfg_%0d: got done+%0d wt %0d act %0d busy %0d expected 1 0 0 0",
                         j, done_cyc - t0, n_wt, n_act, n_busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        int extra = 0;
        fill_random(2, 2, 2);
        stray_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1 stray_rdy = 1'b0;
        run_job(2, 2, 2, 0, 1, "start_while_busy");
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (o_busy || o_wt_rd_en || o_act_rd_en || o_done) extra++;
        end
        tests_run++;
        if (extra !== 0) begin
            tests_failed++;
            $display("[TB] FAIL ignored_start: got %0d active cycles after done expected 0", extra);
        end
        @(posedge clk); #1;
        fill_random(1, 3, 5);
        run_job(1, 3, 5, 1, 0, "back_to_back");
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        fill_random(2, 3, 4);
        i_cfg_rows = 9'd2; i_cfg_chunks = 7'd3; i_cfg_batch = 4'd4;
        i_res_ready = 1'b1;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            @(negedge clk);
            if (o_act_rd_en && o_core_data_valid) seen = 1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_stream: got no STREAM cycle expected one within 12 cycles");
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({o_busy, o_done, o_wt_rd_en, o_act_rd_en, o_core_load_weight, o_core_data_valid,
             o_res_valid} !== 7'b0 || o_res_data !== 0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_outputs: got %b expected 0000000",
                     {o_busy, o_done, o_wt_rd_en, o_act_rd_en, o_core_load_weight,
                      o_core_data_valid, o_res_valid});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_job(2, 3, 4, 1, 0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_chunks();
        test_random_gemv();
        test_drain_stall();
        test_zero_cfg();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
